// File: rtl/rst_sync_pkg.sv
// Shared types and constants for the reset synchronizer / release sequencer.
package rst_sync_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } rst_seq_state_t;

  localparam int MIN_NUM_STAGES = 2;
  localparam int MIN_NUM_CH     = 1;
  localparam int MIN_CYC        = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Bare N-flop reset synchronizer: asynchronous clear, synchronous release of SYNC_OUT.
module rst_sync_chain
  import rst_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic SYNC_OUT
);

  if (NUM_STAGES < MIN_NUM_STAGES) begin : g_bad_stages
    $error("rst_sync_chain: NUM_STAGES must be >= 2");
  end

  logic [NUM_STAGES-1:0] chain_reg;
  logic [NUM_STAGES-1:0] chain_next;

  genvar gi;
  for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign chain_next[gi] = 1'b1;
    end else begin : g_body
      assign chain_next[gi] = chain_reg[gi-1];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= chain_next;
    end
  end

  assign SYNC_OUT = chain_reg[NUM_STAGES-1];

endmodule

// File: rtl/rst_sync_seq.sv
// Multi-channel reset synchronizer and in-order release sequencer.
// Optional software reset request port enabled by RST_SYNC_SWRST_EN.
module rst_sync_seq
  import rst_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_CH      = 3,
  parameter int STRETCH_CYC = 16,
  parameter int GAP_CYC     = 4
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef RST_SYNC_SWRST_EN
  input  logic              SW_RST_REQ,
`endif
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE
);

  localparam int CNT_W = $clog2(max_int(STRETCH_CYC, GAP_CYC) + 1);
  localparam int IDX_W = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH - 1);

  if (NUM_CH < MIN_NUM_CH) begin : g_bad_ch
    $error("rst_sync_seq: NUM_CH must be >= 1");
  end
  if (STRETCH_CYC < MIN_CYC) begin : g_bad_stretch
    $error("rst_sync_seq: STRETCH_CYC must be >= 1");
  end
  if (GAP_CYC < MIN_CYC) begin : g_bad_gap
    $error("rst_sync_seq: GAP_CYC must be >= 1");
  end

  logic chain_tail;
  logic sw_req;

`ifdef RST_SYNC_SWRST_EN
  assign sw_req = SW_RST_REQ;
`else
  assign sw_req = 1'b0;
`endif

  rst_sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_chain (
    .CLK     (CLK),
    .RST     (RST),
    .SYNC_OUT(chain_tail)
  );

  rst_seq_state_t    state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [NUM_CH-1:0] sync_rst_reg, sync_rst_next;
  logic              done_reg, done_next;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= SYNC;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      sync_rst_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      sync_rst_reg <= sync_rst_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    sync_rst_next = sync_rst_reg;
    done_next     = done_reg;
    unique case (state_reg)
      SYNC: begin
        if (chain_tail) begin
          state_next = STRETCH;
          cnt_next   = '0;
        end
      end
      STRETCH: begin
        if (cnt_reg == STRETCH_LAST) begin
          sync_rst_next[0] = 1'b1;
          cnt_next         = '0;
          if (NUM_CH == 1) begin
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            idx_next   = IDX_W'(1);
            state_next = RELEASE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_reg == GAP_LAST) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (idx_reg == IDX_W'(i)) sync_rst_next[i] = 1'b1;
          end
          idx_next = idx_reg + IDX_W'(1);
          cnt_next = '0;
          if (idx_reg == LAST_IDX) begin
            done_next  = 1'b1;
            state_next = DONE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
      end
      default: state_next = SYNC;
    endcase
    // A software request restarts the stretch once the synchronizer has released.
    if (sw_req && (state_reg != SYNC)) begin
      state_next    = STRETCH;
      cnt_next      = '0;
      idx_next      = '0;
      sync_rst_next = '0;
      done_next     = 1'b0;
    end
  end

  assign SYNC_RST = sync_rst_reg;
  assign RST_DONE = done_reg;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Self-checking bench for rst_sync_seq: default instance plus a single-channel instance.
module tb_rst_sync_seq;

  localparam int S1 = 2, C1 = 3, ST1 = 16, G1 = 4;
  localparam int S2 = 3, C2 = 1, ST2 = 5,  G2 = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         sw  = 1'b0;
  logic [C1-1:0] sync_a;
  logic          done_a;
  logic [C2-1:0] sync_b;
  logic          done_b;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int base_a = S1 + 1;
  localparam int BASE_B = S2 + 1;

  always #5 CLK = ~CLK;

  rst_sync_seq #(.NUM_STAGES(S1), .NUM_CH(C1), .STRETCH_CYC(ST1), .GAP_CYC(G1)) dut_a (
    .CLK       (CLK),
    .RST       (RST),
`ifdef RST_SYNC_SWRST_EN
    .SW_RST_REQ(sw),
`endif
    .SYNC_RST  (sync_a),
    .RST_DONE  (done_a)
  );

  rst_sync_seq #(.NUM_STAGES(S2), .NUM_CH(C2), .STRETCH_CYC(ST2), .GAP_CYC(G2)) dut_b (
    .CLK       (CLK),
    .RST       (RST),
`ifdef RST_SYNC_SWRST_EN
    .SW_RST_REQ(1'b0),
`endif
    .SYNC_RST  (sync_b),
    .RST_DONE  (done_b)
  );

  // Edge numbering since RST release; base is the edge from which the stretch counts.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      k      <= 0;
      base_a <= S1 + 1;
    end else begin
      k <= k + 1;
      if (sw && (k + 1 >= S1 + 2)) base_a <= k + 1;
    end
  end

  function automatic logic [7:0] exp_vec(input int e, input int base, input int st,
                                         input int gap, input int nch);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < nch; i++) v[i] = (e >= base + st + i * gap);
    return v;
  endfunction

  function automatic logic exp_done(input int e, input int base, input int st,
                                    input int gap, input int nch);
    return (e >= base + st + (nch - 1) * gap);
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at edge %0d: got %b want %b", nm, k, act, req);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge CLK);
      #4;
      check("model_a_sync", 8'(sync_a), exp_vec(k, base_a, ST1, G1, C1));
      check("model_a_done", 8'(done_a), 8'(exp_done(k, base_a, ST1, G1, C1)));
      check("model_b_sync", 8'(sync_b), exp_vec(k, BASE_B, ST2, G2, C2));
      check("model_b_done", 8'(done_b), 8'(exp_done(k, BASE_B, ST2, G2, C2)));
    end
  end

  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (k < n && guard < 300) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    total++;
    if (k != n) begin
      bad++;
      $display("FAIL wait_edge: reached %0d want %0d", k, n);
    end
    #2;
  endtask

  task automatic release_rst();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic pin_a(input int n, input logic [2:0] v, input logic d);
    wait_edge(n);
    check("lit_a_sync", 8'(sync_a), 8'(v));
    check("lit_a_done", 8'(done_a), 8'(d));
  endtask

  initial begin
    RST = 1'b0;
    sw  = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    check("reset_sync", 8'(sync_a), 8'h00);
    check("reset_done", 8'(done_a), 8'h00);
    release_rst();
    pin_a(8, 3'b000, 1'b0);
    check("lit_b_pre", 8'({sync_b, done_b}), 8'b00);
    pin_a(9, 3'b000, 1'b0);
    check("lit_b_rel", 8'({sync_b, done_b}), 8'b11);
    pin_a(18, 3'b000, 1'b0);
    pin_a(19, 3'b001, 1'b0);
    // Asynchronous drop between edges 21 and 22.
    wait_edge(21);
    RST = 1'b0;
    #1;
    check("async_sync", 8'(sync_a), 8'h00);
    check("async_done", 8'(done_a), 8'h00);
    repeat (2) @(posedge CLK);
    release_rst();
    pin_a(18, 3'b000, 1'b0);
    pin_a(19, 3'b001, 1'b0);
    pin_a(22, 3'b001, 1'b0);
    pin_a(23, 3'b011, 1'b0);
    pin_a(26, 3'b011, 1'b0);
    pin_a(27, 3'b111, 1'b1);
`ifdef RST_SYNC_SWRST_EN
    wait_edge(39);
    sw = 1'b1;
    pin_a(40, 3'b000, 1'b0);
    sw = 1'b0;
    pin_a(55, 3'b000, 1'b0);
    pin_a(56, 3'b001, 1'b0);
    pin_a(60, 3'b011, 1'b0);
    pin_a(64, 3'b111, 1'b1);
    // Request in SYNC is ignored; request in RELEASE restarts the stretch.
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    sw  = 1'b1;
    wait_edge(1);
    sw = 1'b0;
    pin_a(19, 3'b001, 1'b0);
    wait_edge(24);
    sw = 1'b1;
    pin_a(25, 3'b000, 1'b0);
    sw = 1'b0;
    pin_a(40, 3'b000, 1'b0);
    pin_a(41, 3'b001, 1'b0);
    pin_a(49, 3'b111, 1'b1);
`else
    pin_a(45, 3'b111, 1'b1);
`endif
    @(posedge CLK);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
